wb_regfile_hilo: RTL and testbench

//  Write-back stage sink for the MEM/WB pipeline register outputs.
//  - Selects the write-back data (MemtoReg mux) and commits it to the 32-entry GPR file.
//  - Commits HI/LO on RegWrite2.
//  - Serves two combinational GPR read ports plus HI/LO reads to the decode stage.
//  - Keeps a retired-write counter for debug.

---
 rtl/wb_regfile_hilo_if.sv | 37 +++
 rtl/wb_regfile_hilo.sv | 93 +++++++++
 tb/tb_wb_regfile_hilo.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_hilo_if.sv
// Write-back bus for wb_regfile_hilo: MEM/WB commit inputs, decode-stage
// read ports, and the forwarding/debug outputs. The master drives commits
// and read addresses. The slave (the register file) returns read data.
interface wb_regfile_hilo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              WB_RegWrite;
  logic              WB_RegWrite2;
  logic              WB_MemtoReg;
  logic [DATA_W-1:0] WB_ReadData;
  logic [DATA_W-1:0] WB_ALUResult;
  logic [ADDR_W-1:0] WB_RegDstData;
  logic [DATA_W-1:0] WB_HI;
  logic [DATA_W-1:0] WB_LO;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [DATA_W-1:0] HI_Out;
  logic [DATA_W-1:0] LO_Out;
  logic [DATA_W-1:0] WriteData;
  logic [CNT_W-1:0]  WriteCount;

  modport master (
    output WB_RegWrite, WB_RegWrite2, WB_MemtoReg, WB_ReadData, WB_ALUResult,
           WB_RegDstData, WB_HI, WB_LO, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, HI_Out, LO_Out, WriteData, WriteCount
  );

  modport slave (
    input  WB_RegWrite, WB_RegWrite2, WB_MemtoReg, WB_ReadData, WB_ALUResult,
           WB_RegDstData, WB_HI, WB_LO, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, HI_Out, LO_Out, WriteData, WriteCount
  );
endinterface

// File: rtl/wb_regfile_hilo.sv
// Write-back stage sink: MemtoReg mux, 32-entry GPR file (entry 0 reads 0),
// HI/LO registers, two combinational GPR read ports, and a retired-write
// counter for debug.
// Optional feature macro WB_BYPASS_EN: same-cycle write-to-read forwarding
// on the GPR read ports and on HI/LO. When it is undefined, reads return
// registered state only.
module wb_regfile_hilo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic                 Clk,
  input  logic                 Clr_n,
  wb_regfile_hilo_if.slave     wb
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] gpr [DEPTH];
  logic [DATA_W-1:0] hiReg;
  logic [DATA_W-1:0] loReg;
  logic [CNT_W-1:0]  writeCount;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic [DATA_W-1:0] hiOut;
  logic [DATA_W-1:0] loOut;

  // Write-back data select; also exported to the forwarding unit.
  always_comb begin
    writeData = wb.WB_MemtoReg ? wb.WB_ReadData : wb.WB_ALUResult;
  end

  // GPR commit; writes to entry 0 are dropped so it stays zero.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      for (int i = 0; i < DEPTH; i++) gpr[i] <= '0;
    end else if (wb.WB_RegWrite && (wb.WB_RegDstData != '0)) begin
      gpr[wb.WB_RegDstData] <= writeData;
    end
  end

  // HI/LO commit, both halves on the same edge.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (wb.WB_RegWrite2) begin
      hiReg <= wb.WB_HI;
      loReg <= wb.WB_LO;
    end
  end

  // Retired-write counter: one per cycle with any commit, wraps silently.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      writeCount <= '0;
    end else if (wb.WB_RegWrite || wb.WB_RegWrite2) begin
      writeCount <= writeCount + CNT_W'(1);
    end
  end

  // GPR read ports; address 0 is forced to zero regardless of storage.
  always_comb begin
    readData1 = (wb.ReadReg1 == '0) ? '0 : gpr[wb.ReadReg1];
    readData2 = (wb.ReadReg2 == '0) ? '0 : gpr[wb.ReadReg2];
`ifdef WB_BYPASS_EN
    if (wb.WB_RegWrite && (wb.ReadReg1 == wb.WB_RegDstData) && (wb.ReadReg1 != '0))
      readData1 = writeData;
    if (wb.WB_RegWrite && (wb.ReadReg2 == wb.WB_RegDstData) && (wb.ReadReg2 != '0))
      readData2 = writeData;
`endif
  end

  // HI/LO read path, forwarded in the commit cycle when bypass is built in.
  always_comb begin
`ifdef WB_BYPASS_EN
    hiOut = wb.WB_RegWrite2 ? wb.WB_HI : hiReg;
    loOut = wb.WB_RegWrite2 ? wb.WB_LO : loReg;
`else
    hiOut = hiReg;
    loOut = loReg;
`endif
  end

  assign wb.WriteData  = writeData;
  assign wb.ReadData1  = readData1;
  assign wb.ReadData2  = readData2;
  assign wb.HI_Out     = hiOut;
  assign wb.LO_Out     = loOut;
  assign wb.WriteCount = writeCount;

endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Bench for wb_regfile_hilo: directed steps followed by randomized traffic,
// checked against an array-based model of the register file. WriteCount is
// built narrow (8 bits) so the all-ones to zero wrap is reached naturally.
module tb_wb_regfile_hilo;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 8;
  localparam int CMOD = 1 << CW;

  logic Clk = 1'b0;
  logic Clr_n = 1'b1;
  always #5 Clk = ~Clk;

  wb_regfile_hilo_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

  wb_regfile_hilo #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .Clk   (Clk),
    .Clr_n (Clr_n),
    .wb    (bus)
  );

  // Reference state
  logic [DW-1:0] mGpr [32];
  logic [DW-1:0] mHi;
  logic [DW-1:0] mLo;
  int unsigned   mCnt;

  int nVec = 0;
  int nErr = 0;

  function automatic logic [DW-1:0] expWd();
    return bus.WB_MemtoReg ? bus.WB_ReadData : bus.WB_ALUResult;
  endfunction

  function automatic logic [DW-1:0] expRd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef WB_BYPASS_EN
    if (bus.WB_RegWrite && a == bus.WB_RegDstData) return expWd();
`endif
    return mGpr[a];
  endfunction

  function automatic logic [DW-1:0] expHi();
`ifdef WB_BYPASS_EN
    if (bus.WB_RegWrite2) return bus.WB_HI;
`endif
    return mHi;
  endfunction

  function automatic logic [DW-1:0] expLo();
`ifdef WB_BYPASS_EN
    if (bus.WB_RegWrite2) return bus.WB_LO;
`endif
    return mLo;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mGpr[i] = '0;
    mHi = '0;
    mLo = '0;
    mCnt = 0;
  endtask

  task automatic modelCommit();
    logic [DW-1:0] wd;
    wd = expWd();
    if (bus.WB_RegWrite && bus.WB_RegDstData != 0) mGpr[bus.WB_RegDstData] = wd;
    if (bus.WB_RegWrite2) begin
      mHi = bus.WB_HI;
      mLo = bus.WB_LO;
    end
    if (bus.WB_RegWrite || bus.WB_RegWrite2) mCnt = (mCnt + 1) % CMOD;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    check({tag, "_rd1"}, bus.ReadData1, expRd(bus.ReadReg1));
    check({tag, "_rd2"}, bus.ReadData2, expRd(bus.ReadReg2));
    check({tag, "_hi"},  bus.HI_Out, expHi());
    check({tag, "_lo"},  bus.LO_Out, expLo());
    check({tag, "_wd"},  bus.WriteData, expWd());
    check({tag, "_cnt"}, DW'(bus.WriteCount), DW'(mCnt));
  endtask

  // Advance one clock; model commits with the inputs seen at the edge.
  task automatic tick();
    @(posedge Clk);
    if (Clr_n) modelCommit();
    #1;
  endtask

  task automatic idle();
    bus.WB_RegWrite   = 1'b0;
    bus.WB_RegWrite2  = 1'b0;
    bus.WB_MemtoReg   = 1'b0;
    bus.WB_ReadData   = $urandom;
    bus.WB_ALUResult  = $urandom;
    bus.WB_RegDstData = AW'($urandom);
    bus.WB_HI         = $urandom;
    bus.WB_LO         = $urandom;
  endtask

  task automatic sweep(input string tag);
    idle();
    for (int i = 0; i < 32; i++) begin
      bus.ReadReg1 = AW'(i);
      bus.ReadReg2 = AW'(31 - i);
      #1;
      check({tag, "_sw1"}, bus.ReadData1, expRd(bus.ReadReg1));
      check({tag, "_sw2"}, bus.ReadData2, expRd(bus.ReadReg2));
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    modelReset();
    idle();
    bus.ReadReg1 = '0;
    bus.ReadReg2 = '0;

    // Power-on reset
    #1 Clr_n = 1'b0;
    #1;
    checkAll("por");
    tick();
    tick();
    @(negedge Clk);
    Clr_n = 1'b1;
    @(posedge Clk);
    #1;

    // Test 1: load GPR5, HI, LO, then async reset mid-cycle
    bus.WB_RegWrite = 1'b1; bus.WB_MemtoReg = 1'b0;
    bus.WB_ALUResult = 32'hDEADBEEF; bus.WB_RegDstData = 5'd5;
    bus.WB_RegWrite2 = 1'b1; bus.WB_HI = 32'h0BAD_F00D; bus.WB_LO = 32'h1234_0000;
    tick();
    idle();
    bus.ReadReg1 = 5'd5;
    #1;
    check("t1_load5", bus.ReadData1, 32'hDEADBEEF);
    checkAll("t1_pre");
    Clr_n = 1'b0;
    #1;
    modelReset();
    check("t1_gpr5", bus.ReadData1, 32'h0);
    check("t1_hi", bus.HI_Out, 32'h0);
    check("t1_lo", bus.LO_Out, 32'h0);
    check("t1_cnt", DW'(bus.WriteCount), 32'h0);
    // A write pending while reset is held is discarded
    bus.WB_RegWrite = 1'b1; bus.WB_ALUResult = 32'h1111_2222; bus.WB_RegDstData = 5'd5;
    bus.WB_RegWrite2 = 1'b1;
    tick();
    idle();
    #1;
    check("t1_drop5", bus.ReadData1, 32'h0);
    check("t1_dropcnt", DW'(bus.WriteCount), 32'h0);
    @(negedge Clk);
    Clr_n = 1'b1;
    @(posedge Clk);
    #1;

    // Test 2: load path through MemtoReg, first commit after release
    bus.WB_RegWrite = 1'b1; bus.WB_MemtoReg = 1'b1;
    bus.WB_ReadData = 32'h12345678; bus.WB_ALUResult = 32'hAAAA0000;
    bus.WB_RegDstData = 5'd7;
    #1;
    check("t2_wd", bus.WriteData, 32'h12345678);
    tick();
    idle();
    bus.ReadReg1 = 5'd7;
    #1;
    check("t2_rd7", bus.ReadData1, 32'h12345678);
    check("t2_cnt", DW'(bus.WriteCount), 32'h1);

    // Test 3: write to GPR0 is dropped but counted
    bus.WB_RegWrite = 1'b1; bus.WB_MemtoReg = 1'b0;
    bus.WB_ALUResult = 32'hFFFFFFFF; bus.WB_RegDstData = 5'd0;
    bus.ReadReg2 = 5'd0;
    tick();
    idle();
    #1;
    check("t3_rd0", bus.ReadData2, 32'h0);
    check("t3_cnt", DW'(bus.WriteCount), 32'h2);

    // Test 4: GPR and HI/LO commit in the same cycle
    bus.WB_RegWrite = 1'b1; bus.WB_MemtoReg = 1'b0;
    bus.WB_ALUResult = 32'h55; bus.WB_RegDstData = 5'd3;
    bus.WB_RegWrite2 = 1'b1; bus.WB_HI = 32'h1; bus.WB_LO = 32'h2;
    bus.ReadReg1 = 5'd3;
    #1;
`ifdef WB_BYPASS_EN
    check("t4_pre_rd1", bus.ReadData1, 32'h55);
    check("t4_pre_hi", bus.HI_Out, 32'h1);
`else
    check("t4_pre_rd1", bus.ReadData1, 32'h0);
    check("t4_pre_hi", bus.HI_Out, 32'h0);
`endif
    checkAll("t4_pre");
    tick();
    idle();
    #1;
    check("t4_rd1", bus.ReadData1, 32'h55);
    check("t4_hi", bus.HI_Out, 32'h1);
    check("t4_lo", bus.LO_Out, 32'h2);
    check("t4_cnt", DW'(bus.WriteCount), 32'h3);

    // Test 6: both ports on the same address
    bus.WB_RegWrite = 1'b1; bus.WB_MemtoReg = 1'b0;
    bus.WB_ALUResult = 32'hCAFE; bus.WB_RegDstData = 5'd9;
    tick();
    idle();
    bus.ReadReg1 = 5'd9;
    bus.ReadReg2 = 5'd9;
    #1;
    check("t6_rd1", bus.ReadData1, 32'hCAFE);
    check("t6_rd2", bus.ReadData2, 32'hCAFE);
    sweep("dir");

    // Test 5: hold RegWrite until the counter reaches all-ones, then wrap
    begin
      int guard;
      guard = 0;
      while (mCnt != CMOD - 1 && guard < 2 * CMOD) begin
        bus.WB_RegWrite = 1'b1;
        bus.WB_MemtoReg = 1'($urandom);
        bus.WB_ReadData = $urandom;
        bus.WB_ALUResult = $urandom;
        bus.WB_RegDstData = AW'($urandom);
        tick();
        guard++;
      end
      check("t5_reach", DW'(mCnt), DW'(CMOD - 1));
      check("t5_ones", DW'(bus.WriteCount), DW'(CMOD - 1));
      tick();
      #1;
      check("t5_wrap0", DW'(bus.WriteCount), 32'h0);
      tick();
      #1;
      check("t5_wrap1", DW'(bus.WriteCount), 32'h1);
      checkAll("t5_post");
    end

    // Randomized traffic with occasional asynchronous reset pulses
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) == 0) begin
        Clr_n = 1'b0;
        #1;
        modelReset();
        Clr_n = 1'b1;
      end
      bus.WB_RegWrite   = ($urandom_range(3) != 0);
      bus.WB_RegWrite2  = ($urandom_range(2) == 0);
      bus.WB_MemtoReg   = 1'($urandom);
      bus.WB_ReadData   = $urandom;
      bus.WB_ALUResult  = $urandom;
      bus.WB_RegDstData = AW'($urandom);
      bus.WB_HI         = $urandom;
      bus.WB_LO         = $urandom;
      bus.ReadReg1      = ($urandom_range(3) == 0) ? bus.WB_RegDstData : AW'($urandom);
      bus.ReadReg2      = ($urandom_range(3) == 0) ? bus.WB_RegDstData : AW'($urandom);
      #1;
      checkAll("rnd_pre");
      tick();
      checkAll("rnd_post");
    end
    sweep("end");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
